// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, prefetch entry layout
// and architectural constants used by the fetch stage and its FIFO.
package cpu_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        RESET,
        FETCH,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] next_pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_if.sv
// Bundle of the fetch stage's instruction-memory handshake and IF/ID-facing
// signals; master is the fetch stage, slave is memory plus the pipeline.
interface if_fetch_if;

    logic        stall_i;
    logic        branch_i;
    logic [31:0] branchAddr_i;
    logic        imemReq_o;
    logic [31:0] imemAddr_o;
    logic        imemAck_i;
    logic [31:0] imemData_i;
    logic [31:0] inst_o;
    logic [31:0] nextPC_o;
    logic        instValid_o;
    logic        IFFlush_o;

    modport master (
        input  stall_i, branch_i, branchAddr_i, imemAck_i, imemData_i,
        output imemReq_o, imemAddr_o, inst_o, nextPC_o, instValid_o, IFFlush_o
    );

    modport slave (
        output stall_i, branch_i, branchAddr_i, imemAck_i, imemData_i,
        input  imemReq_o, imemAddr_o, inst_o, nextPC_o, instValid_o, IFFlush_o
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular prefetch buffer of {nextPC, inst} entries; flush beats
// push/pop, and a push into a full buffer is accepted only alongside a pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk_i,
    input  logic         start_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t push_data_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: keeps one memory request in flight, buffers
// returned words in a prefetch FIFO and redirects on ID-resolved branches.
module if_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input logic        clk_i,
    input logic        start_i,
    if_fetch_if.master bus
);

    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam int            NW      = CW + 1;
    localparam logic [NW-1:0] DEPTH_N = NW'(FIFO_DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;

    logic          push, pop, flush;
    fetch_entry_t  push_data, head;
    logic [CW-1:0] count;
    logic [NW-1:0] count_next;
    logic          ack, inst_valid;
    logic [31:0]   target, addr_plus4;

    assign target     = {bus.branchAddr_i[31:2], 2'b00};
    assign addr_plus4 = addr_q + 32'd4;
    assign ack        = req_q && bus.imemAck_i;
    assign inst_valid = (count != '0);
    assign push_data  = {addr_plus4, bus.imemData_i};

    // A new request only launches when nothing is in flight (or it was just
    // acked), so imemAddr_o never moves under a pending request.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        count_next = {1'b0, count};
        case (state_q)
            RESET: begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = fetch_pc_q;
                if (bus.branch_i) begin
                    flush      = 1'b1;
                    fetch_pc_d = target;
                    addr_d     = target;
                end
            end
            FETCH: begin
                if (bus.branch_i) begin
                    flush      = 1'b1;
                    fetch_pc_d = target;
                    if (req_q && !bus.imemAck_i) begin
                        state_d = DRAIN;
                    end else begin
                        req_d  = 1'b1;
                        addr_d = target;
                    end
                end else begin
                    push = ack;
                    pop  = inst_valid && !bus.stall_i;
                    if (ack) begin
                        fetch_pc_d = addr_plus4;
                    end
                    count_next = {1'b0, count} + NW'(push) - NW'(pop);
                    req_d      = (count_next < DEPTH_N);
                    if (req_d && (!req_q || ack)) begin
                        addr_d = fetch_pc_d;
                    end
                end
            end
            DRAIN: begin
                flush = bus.branch_i;
                if (bus.branch_i) begin
                    fetch_pc_d = target;
                end
                if (ack) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_d;
                end
            end
            default: begin
                state_d = RESET;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            state_q    <= RESET;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i       (clk_i),
        .start_i     (start_i),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (flush),
        .push_data_i (push_data),
        .head_o      (head),
        .count_o     (count)
    );

    assign bus.imemReq_o   = req_q;
    assign bus.imemAddr_o  = addr_q;
    assign bus.instValid_o = inst_valid;
    assign bus.inst_o      = inst_valid ? head.inst : NOP_INST;
    assign bus.nextPC_o    = inst_valid ? head.next_pc : 32'h0;
    assign bus.IFFlush_o   = bus.branch_i;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by random
// stall/branch/wait-state traffic checked against a program-order model.
module tb_if_fetch;
    import cpu_pkg::*;

    logic clk_i = 1'b0;
    logic start_i;

    if_fetch_if bus ();

    if_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i   (clk_i),
        .start_i (start_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_pc;
    int          delivered;
    int          wait_n;
    int          wcnt;
    bit          mem_const;
    bit          mem_auto;
    logic        man_ack;
    logic [31:0] man_data;
    logic        mem_ack;
    logic [31:0] mem_data;

    // Every address holds a distinct word, so a wrong or stale fetch is visible.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory with a programmable number of wait cycles per request.
    always @(negedge clk_i) begin
        if (bus.imemReq_o === 1'b1) begin
            if (wcnt >= wait_n) begin
                mem_ack  <= 1'b1;
                mem_data <= mem_const ? 32'h2000_0001 : memf(bus.imemAddr_o);
                wcnt     <= 0;
            end else begin
                mem_ack  <= 1'b0;
                wcnt     <= wcnt + 1;
            end
        end else begin
            mem_ack <= 1'b0;
            wcnt    <= 0;
        end
    end

    assign bus.imemAck_i  = mem_auto ? mem_ack : man_ack;
    assign bus.imemData_i = mem_auto ? mem_data : man_data;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // One pipeline cycle: check the presented head against the program-order
    // model, drive stall/branch, then advance the model by what IF/ID consumes.
    task automatic apply_stimulus(input logic st, input logic br, input logic [31:0] ba);
        if (bus.instValid_o === 1'b1) begin
            check_output("head_inst", bus.inst_o, memf(exp_pc));
            check_output("head_nextpc", bus.nextPC_o, exp_pc + 32'd4);
        end else begin
            check_output("empty_inst", bus.inst_o, 32'h0);
            check_output("empty_nextpc", bus.nextPC_o, 32'h0);
        end
        bus.stall_i      = st;
        bus.branch_i     = br;
        bus.branchAddr_i = ba;
        #1;
        check_output("ifflush", 32'(bus.IFFlush_o), 32'(br));
        if (br) begin
            exp_pc = {ba[31:2], 2'b00};
        end else if (bus.instValid_o === 1'b1 && !st) begin
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        next_cycle();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 24; i++) begin
            if (bus.imemReq_o === 1'b0) break;
            apply_stimulus(1'b1, 1'b0, 32'h0);
        end
        check_output("fifo_full_idle", 32'(bus.imemReq_o), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_req"}, 32'(bus.imemReq_o), 32'h0);
        check_output({tag, "_addr"}, bus.imemAddr_o, 32'h0);
        check_output({tag, "_inst"}, bus.inst_o, 32'h0);
        check_output({tag, "_nextpc"}, bus.nextPC_o, 32'h0);
        check_output({tag, "_valid"}, 32'(bus.instValid_o), 32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        start_i          = 1'b0;
        bus.stall_i      = 1'b0;
        bus.branch_i     = 1'b0;
        bus.branchAddr_i = 32'h0;
        wait_n           = 0;
        wcnt             = 0;
        mem_const        = 1'b1;
        mem_auto         = 1'b1;
        man_ack          = 1'b0;
        man_data         = 32'h0;
        exp_pc           = 32'h0;
        delivered        = 0;

        // Reset, then zero-wait streaming of a constant word.
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        start_i = 1'b1;
        next_cycle();
        check_output("first_req", 32'(bus.imemReq_o), 32'h1);
        check_output("first_addr", bus.imemAddr_o, 32'h0);
        check_output("first_valid", 32'(bus.instValid_o), 32'h0);
        next_cycle();
        check_output("first_inst", bus.inst_o, 32'h2000_0001);
        check_output("first_nextpc", bus.nextPC_o, 32'h4);
        check_output("addr_4", bus.imemAddr_o, 32'h4);
        next_cycle();
        check_output("addr_8", bus.imemAddr_o, 32'h8);
        check_output("second_nextpc", bus.nextPC_o, 32'h8);
        next_cycle();
        check_output("addr_12", bus.imemAddr_o, 32'hC);

        // Restart with address-dependent memory contents.
        start_i   = 1'b0;
        mem_const = 1'b0;
        next_cycle();
        next_cycle();
        check_reset_outputs("reset2");
        exp_pc  = 32'h0;
        start_i = 1'b1;
        repeat (6) apply_stimulus(1'b0, 1'b0, 32'h0);

        // Hazard stall: head frozen, FIFO fills, fetch resumes afterwards.
        repeat (3) apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("stall_req_drop", 32'(bus.imemReq_o), 32'h0);
        check_output("stall_valid", 32'(bus.instValid_o), 32'h1);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("stall_resume_req", 32'(bus.imemReq_o), 32'h1);
        repeat (3) apply_stimulus(1'b0, 1'b0, 32'h0);

        // Redirect with no request in flight.
        wait_idle();
        apply_stimulus(1'b0, 1'b1, 32'h0000_0103);
        check_output("br_flush_valid", 32'(bus.instValid_o), 32'h0);
        check_output("br_target_addr", bus.imemAddr_o, 32'h100);
        check_output("br_target_req", 32'(bus.imemReq_o), 32'h1);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("br_target_inst", bus.inst_o, memf(32'h100));
        repeat (3) apply_stimulus(1'b0, 1'b0, 32'h0);

        // Redirect while a 3-wait fetch of 0x40 is pending.
        wait_idle();
        wait_n = 3;
        apply_stimulus(1'b0, 1'b1, 32'h0000_0040);
        check_output("w3_addr40", bus.imemAddr_o, 32'h40);
        apply_stimulus(1'b0, 1'b1, 32'h0000_0200);
        check_output("drain_addr_hold", bus.imemAddr_o, 32'h40);
        check_output("drain_req_hold", 32'(bus.imemReq_o), 32'h1);
        check_output("drain_valid", 32'(bus.instValid_o), 32'h0);
        repeat (2) apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("drain_still_40", bus.imemAddr_o, 32'h40);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("drain_target_addr", bus.imemAddr_o, 32'h200);
        check_output("drain_target_req", 32'(bus.imemReq_o), 32'h1);
        for (int i = 0; i < 10; i++) begin
            if (bus.instValid_o === 1'b1) break;
            apply_stimulus(1'b0, 1'b0, 32'h0);
        end
        check_output("drain_target_valid", 32'(bus.instValid_o), 32'h1);
        check_output("drain_target_inst", bus.inst_o, memf(32'h200));

        // Branch to the top word: PC+4 wraps to zero.
        wait_idle();
        wait_n = 0;
        apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        check_output("wrap_addr", bus.imemAddr_o, 32'hFFFF_FFFC);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("wrap_nextpc", bus.nextPC_o, 32'h0);
        check_output("wrap_next_addr", bus.imemAddr_o, 32'h0);
        check_output("wrap_inst", bus.inst_o, memf(32'hFFFF_FFFC));

        // Reset while a request is outstanding; the late ack must be ignored.
        wait_idle();
        mem_auto = 1'b0;
        man_ack  = 1'b0;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("abandon_req", 32'(bus.imemReq_o), 32'h1);
        start_i = 1'b0;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        exp_pc   = 32'h0;
        man_ack  = 1'b1;
        man_data = 32'hDEAD_BEEF;
        check_reset_outputs("rst_mid");
        repeat (2) apply_stimulus(1'b0, 1'b0, 32'h0);
        check_reset_outputs("rst_late_ack");
        man_ack  = 1'b0;
        mem_auto = 1'b1;
        start_i  = 1'b1;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("restart_req", 32'(bus.imemReq_o), 32'h1);
        check_output("restart_addr", bus.imemAddr_o, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("restart_valid", 32'(bus.instValid_o), 32'h1);
        check_output("restart_inst", bus.inst_o, memf(32'h0));

        // Random stalls, branches and wait states against the model.
        delivered = 0;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) wait_n = int'($urandom_range(0, 2));
            apply_stimulus($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom);
        end
        check_output("rand_progress", 32'(delivered >= 40), 32'h1);

        wait_n    = 0;
        delivered = 0;
        repeat (30) apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("stream_progress", 32'(delivered >= 20), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
